// File: rtl/decode_stage_pipe_if.sv
// IF/WB/EX-facing signal bundle of the MIPS-Lite decode stage.
// The slave modport is the decode stage; the master modport is the surrounding pipeline.
interface decode_stage_pipe_if #(
   parameter int DATA  = 32,
   parameter int NREGS = 32
);
   localparam int AW = $clog2(NREGS);

   logic            if_valid;
   logic [31:0]     instruction;
   logic            ex_stall;
   logic            flush;
   logic            wb_en;
   logic [AW-1:0]   wb_addr;
   logic [DATA-1:0] wb_data;

   logic            id_stall;
   logic            halted;
   logic            ex_valid;
   logic [5:0]      ex_opcode;
   logic [AW-1:0]   ex_rs;
   logic [AW-1:0]   ex_rt;
   logic [AW-1:0]   ex_dest;
   logic [DATA-1:0] ex_rs_data;
   logic [DATA-1:0] ex_rt_data;
   logic [DATA-1:0] ex_imm;
   logic            ex_is_load;
   logic            ex_writes_reg;

   modport master (
      output if_valid, instruction, ex_stall, flush, wb_en, wb_addr, wb_data,
      input  id_stall, halted, ex_valid, ex_opcode, ex_rs, ex_rt, ex_dest,
             ex_rs_data, ex_rt_data, ex_imm, ex_is_load, ex_writes_reg
   );

   modport slave (
      input  if_valid, instruction, ex_stall, flush, wb_en, wb_addr, wb_data,
      output id_stall, halted, ex_valid, ex_opcode, ex_rs, ex_rt, ex_dest,
             ex_rs_data, ex_rt_data, ex_imm, ex_is_load, ex_writes_reg
   );
endinterface

// File: rtl/decode_stage_pipe.sv
// MIPS-Lite ID stage: register file, immediate extension, load-use bubble and ID/EX register.
// Define DECODE_BYPASS_EN for write-first register reads (same-cycle write-back visible to decode).
module decode_stage_pipe #(
   parameter int DATA  = 32,
   parameter int NREGS = 32
) (
   input  logic               clk,
   input  logic               rst,
   decode_stage_pipe_if.slave pipe
);
   localparam int AW   = $clog2(NREGS);
   localparam int RF_N = 1 << AW;

   localparam logic [5:0] OP_XOR  = 6'h0A;
   localparam logic [5:0] OP_XORI = 6'h0B;
   localparam logic [5:0] OP_ORI  = 6'h07;
   localparam logic [5:0] OP_ANDI = 6'h09;
   localparam logic [5:0] OP_LDW  = 6'h0C;
   localparam logic [5:0] OP_STW  = 6'h0D;
   localparam logic [5:0] OP_BEQ  = 6'h0F;
   localparam logic [5:0] OP_HALT = 6'h11;

   // Logical immediates zero-extend; everything else sign-extends.
   function automatic logic signed [DATA-1:0] extendImm(input logic [5:0] op, input logic [15:0] imm);
      if (op == OP_ORI || op == OP_ANDI || op == OP_XORI)
         return DATA'(imm);
      return DATA'(signed'(imm));
   endfunction

   logic signed [DATA-1:0] regFile [RF_N];

   logic [5:0]             opcode_p0;
   logic [AW-1:0]          rs_p0, rt_p0, rd_p0, dest_p0;
   logic                   isRType_p0, isIType_p0;
   logic                   writes_p0, usesRs_p0, usesRt_p0, isLoad_p0, isHalt_p0;
   logic signed [DATA-1:0] rsData_p0, rtData_p0, imm_p0;
   logic                   loadUse;

   logic                   vld_p1;
   logic                   halted_p1;
   logic [5:0]             opcode_p1;
   logic [AW-1:0]          rs_p1, rt_p1, dest_p1;
   logic signed [DATA-1:0] rsData_p1, rtData_p1, imm_p1;
   logic                   isLoad_p1, writes_p1;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < RF_N; i++)
            regFile[i] <= '0;
      end else if (pipe.wb_en && pipe.wb_addr != '0) begin
         regFile[pipe.wb_addr] <= pipe.wb_data;
      end
   end

   // ---- stage p0: decode and register read ----
   always_comb begin
      opcode_p0  = pipe.instruction[31:26];
      rs_p0      = pipe.instruction[21 +: AW];
      rt_p0      = pipe.instruction[16 +: AW];
      rd_p0      = pipe.instruction[11 +: AW];
      isRType_p0 = (opcode_p0 <= OP_XOR) && !opcode_p0[0];
      isIType_p0 = ((opcode_p0 <= OP_XORI) && opcode_p0[0]) || (opcode_p0 == OP_LDW);
      writes_p0  = isRType_p0 || isIType_p0;
      dest_p0    = isRType_p0 ? rd_p0 : (isIType_p0 ? rt_p0 : '0);
      usesRs_p0  = (opcode_p0 != OP_HALT);
      usesRt_p0  = isRType_p0 || (opcode_p0 == OP_STW) || (opcode_p0 == OP_BEQ);
      isLoad_p0  = (opcode_p0 == OP_LDW);
      isHalt_p0  = (opcode_p0 == OP_HALT);
      imm_p0     = extendImm(opcode_p0, pipe.instruction[15:0]);
   end

   always_comb begin
      rsData_p0 = regFile[rs_p0];
      rtData_p0 = regFile[rt_p0];
`ifdef DECODE_BYPASS_EN
      if (pipe.wb_en && pipe.wb_addr != '0) begin
         if (pipe.wb_addr == rs_p0)
            rsData_p0 = pipe.wb_data;
         if (pipe.wb_addr == rt_p0)
            rtData_p0 = pipe.wb_data;
      end
`endif
      if (rs_p0 == '0)
         rsData_p0 = '0;
      if (rt_p0 == '0)
         rtData_p0 = '0;
   end

   assign loadUse = pipe.if_valid && vld_p1 && isLoad_p1 && (dest_p1 != '0) &&
                    ((usesRs_p0 && rs_p0 == dest_p1) || (usesRt_p0 && rt_p0 == dest_p1));

   // A flush or reset overrides any hold, so IF is free to move on in those cycles.
   assign pipe.id_stall = !rst && !pipe.flush && (pipe.ex_stall || loadUse);

   // ---- stage p1: ID/EX register ----
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1    <= 1'b0;
         halted_p1 <= 1'b0;
         opcode_p1 <= '0;
         rs_p1     <= '0;
         rt_p1     <= '0;
         dest_p1   <= '0;
         rsData_p1 <= '0;
         rtData_p1 <= '0;
         imm_p1    <= '0;
         isLoad_p1 <= 1'b0;
         writes_p1 <= 1'b0;
      end else if (pipe.flush) begin
         vld_p1 <= 1'b0;
      end else if (!pipe.ex_stall) begin
         if (loadUse) begin
            vld_p1 <= 1'b0;
         end else if (pipe.if_valid && !halted_p1) begin
            vld_p1    <= 1'b1;
            opcode_p1 <= opcode_p0;
            rs_p1     <= rs_p0;
            rt_p1     <= rt_p0;
            dest_p1   <= dest_p0;
            rsData_p1 <= rsData_p0;
            rtData_p1 <= rtData_p0;
            imm_p1    <= imm_p0;
            isLoad_p1 <= isLoad_p0;
            writes_p1 <= writes_p0;
            if (isHalt_p0)
               halted_p1 <= 1'b1;
         end else begin
            vld_p1 <= 1'b0;
         end
      end
   end

   assign pipe.halted        = halted_p1;
   assign pipe.ex_valid      = vld_p1;
   assign pipe.ex_opcode     = opcode_p1;
   assign pipe.ex_rs         = rs_p1;
   assign pipe.ex_rt         = rt_p1;
   assign pipe.ex_dest       = dest_p1;
   assign pipe.ex_rs_data    = rsData_p1;
   assign pipe.ex_rt_data    = rtData_p1;
   assign pipe.ex_imm        = imm_p1;
   assign pipe.ex_is_load    = isLoad_p1;
   assign pipe.ex_writes_reg = writes_p1;
endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed bench for decode_stage_pipe: expected ID/EX contents are queued at issue time
// and checked by a separate monitor whenever ex_valid is presented.
module tb_decode_stage_pipe;
   localparam int DATA  = 32;
   localparam int NREGS = 32;
   localparam int AW    = 5;

`ifdef DECODE_BYPASS_EN
   localparam logic [31:0] BYP_R2 = 32'h12345678;
`else
   localparam logic [31:0] BYP_R2 = 32'h0;
`endif

   typedef struct packed {
      logic [5:0]      op;
      logic [AW-1:0]   rs;
      logic [AW-1:0]   rt;
      logic [AW-1:0]   dest;
      logic [DATA-1:0] rsD;
      logic [DATA-1:0] rtD;
      logic [DATA-1:0] imm;
      logic            ld;
      logic            wr;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   exp_t expQ[$];
   exp_t lastExp;
   bit   haveLast = 0;
   bit   heldEdge = 0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   decode_stage_pipe_if #(.DATA(DATA), .NREGS(NREGS)) pipe ();
   decode_stage_pipe #(.DATA(DATA), .NREGS(NREGS)) dut (.clk(clk), .rst(rst), .pipe(pipe));

   function automatic exp_t mk(input int op, input int rs, input int rt, input int dest,
                               input logic [31:0] rsD, input logic [31:0] rtD,
                               input logic [31:0] imm, input int ld, input int wr);
      exp_t e;
      e.op = 6'(op); e.rs = AW'(rs); e.rt = AW'(rt); e.dest = AW'(dest);
      e.rsD = rsD; e.rtD = rtD; e.imm = imm; e.ld = (ld != 0); e.wr = (wr != 0);
      return e;
   endfunction

   function automatic exp_t actual();
      exp_t a;
      a.op = pipe.ex_opcode; a.rs = pipe.ex_rs; a.rt = pipe.ex_rt; a.dest = pipe.ex_dest;
      a.rsD = pipe.ex_rs_data; a.rtD = pipe.ex_rt_data; a.imm = pipe.ex_imm;
      a.ld = pipe.ex_is_load; a.wr = pipe.ex_writes_reg;
      return a;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, act, want);
      end
   endtask

   // One clock of stimulus; id_stall is checked mid-cycle against the current inputs.
   task automatic cyc(input int v, input logic [31:0] ins, input int st, input int fl,
                      input int we, input int wa, input logic [31:0] wd, input int expStall);
      pipe.if_valid    = (v != 0);
      pipe.instruction = ins;
      pipe.ex_stall    = (st != 0);
      pipe.flush       = (fl != 0);
      pipe.wb_en       = (we != 0);
      pipe.wb_addr     = AW'(wa);
      pipe.wb_data     = wd;
      #2;
      chk("id_stall", 32'(pipe.id_stall), 32'(expStall));
      @(posedge clk);
      #1;
   endtask

   always @(posedge clk)
      heldEdge <= pipe.ex_stall && !pipe.flush && !rst;

   always @(negedge clk) begin
      exp_t act;
      exp_t e;
      if (pipe.ex_valid === 1'b1) begin
         act = actual();
         total++;
         if (heldEdge) begin
            if (!haveLast || act !== lastExp) begin
               bad++;
               $display("FAIL held_idex got=%h want=%h", act, lastExp);
            end
         end else if (expQ.size() == 0) begin
            bad++;
            $display("FAIL unexpected_valid got=%h want=none", act);
         end else begin
            e = expQ.pop_front();
            lastExp = e;
            haveLast = 1;
            if (act !== e) begin
               bad++;
               $display("FAIL idex_contents got=%h want=%h", act, e);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      pipe.if_valid = 1'b0; pipe.instruction = '0; pipe.ex_stall = 1'b0; pipe.flush = 1'b0;
      pipe.wb_en = 1'b0; pipe.wb_addr = '0; pipe.wb_data = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ex_valid", 32'(pipe.ex_valid), 32'd0);
      chk("rst_halted", 32'(pipe.halted), 32'd0);
      chk("rst_opcode", 32'(pipe.ex_opcode), 32'd0);
      chk("rst_dest", 32'(pipe.ex_dest), 32'd0);
      chk("rst_imm", pipe.ex_imm, 32'd0);
      rst = 1'b0;

      // ADDI R1,R0,1000
      expQ.push_back(mk(6'h01, 0, 1, 1, 0, 0, 32'h000003E8, 0, 1));
      cyc(1, 32'h040103E8, 0, 0, 0, 0, 0, 0);

      // Same-cycle write-back of R2, then the reissue sees it in both builds
      expQ.push_back(mk(6'h00, 2, 1, 3, BYP_R2, 0, 32'h00001800, 0, 1));
      cyc(1, 32'h00411800, 0, 0, 1, 2, 32'h12345678, 0);
      expQ.push_back(mk(6'h00, 2, 1, 3, 32'h12345678, 0, 32'h00001800, 0, 1));
      cyc(1, 32'h00411800, 0, 0, 0, 0, 0, 0);

      cyc(0, 0, 0, 0, 1, 1, 32'h11111111, 0);
      chk("idle_bubble", 32'(pipe.ex_valid), 32'd0);

      // LDW R4,0(R2) then dependent ADD R5,R4,R1
      expQ.push_back(mk(6'h0C, 2, 4, 4, 32'h12345678, 0, 0, 1, 1));
      cyc(1, 32'h30440000, 0, 0, 0, 0, 0, 0);
      cyc(1, 32'h00812800, 0, 0, 0, 0, 0, 1);
      chk("loaduse_bubble", 32'(pipe.ex_valid), 32'd0);
      expQ.push_back(mk(6'h00, 4, 1, 5, 0, 32'h11111111, 32'h00002800, 0, 1));
      cyc(1, 32'h00812800, 0, 0, 0, 0, 0, 0);
      chk("loaduse_dest", 32'(pipe.ex_dest), 32'd5);

      // Zero- versus sign-extension of 0xFFFF
      expQ.push_back(mk(6'h07, 0, 6, 6, 0, 0, 32'h0000FFFF, 0, 1));
      cyc(1, 32'h1C06FFFF, 0, 0, 0, 0, 0, 0);
      expQ.push_back(mk(6'h01, 0, 6, 6, 0, 0, 32'hFFFFFFFF, 0, 1));
      cyc(1, 32'h0406FFFF, 0, 0, 0, 0, 0, 0);

      cyc(1, 32'h00411800, 0, 1, 0, 0, 0, 0);
      chk("flush_valid", 32'(pipe.ex_valid), 32'd0);

      // SUB R7,R1,R2 held for 3 cycles; a write to R1 during the hold must not leak in
      expQ.push_back(mk(6'h02, 1, 2, 7, 32'h11111111, 32'h12345678, 32'h00003800, 0, 1));
      cyc(1, 32'h08223800, 0, 0, 0, 0, 0, 0);
      cyc(1, 32'h28224000, 1, 0, 1, 1, 32'h22222222, 1);
      chk("hold_rsdata", pipe.ex_rs_data, 32'h11111111);
      cyc(1, 32'h28224000, 1, 0, 0, 0, 0, 1);
      cyc(1, 32'h28224000, 1, 0, 0, 0, 0, 1);
      chk("hold_dest", 32'(pipe.ex_dest), 32'd7);
      expQ.push_back(mk(6'h0A, 1, 2, 8, 32'h22222222, 32'h12345678, 32'h00004000, 0, 1));
      cyc(1, 32'h28224000, 0, 0, 0, 0, 0, 0);

      // Writes to R0 are dropped
      expQ.push_back(mk(6'h00, 0, 0, 9, 0, 0, 32'h00004800, 0, 1));
      cyc(1, 32'h00004800, 0, 0, 1, 0, 32'h0000DEAD, 0);
      expQ.push_back(mk(6'h00, 0, 0, 9, 0, 0, 32'h00004800, 0, 1));
      cyc(1, 32'h00004800, 0, 0, 0, 0, 0, 0);

      // BEQ: non-writer reports dest 0
      expQ.push_back(mk(6'h0F, 1, 2, 0, 32'h22222222, 32'h12345678, 32'hFFFFFFFE, 0, 0));
      cyc(1, 32'h3C22FFFE, 0, 0, 0, 0, 0, 0);

      cyc(1, 32'h44000000, 0, 1, 0, 0, 0, 0);
      chk("halt_flush_halted", 32'(pipe.halted), 32'd0);
      chk("halt_flush_valid", 32'(pipe.ex_valid), 32'd0);

      expQ.push_back(mk(6'h11, 0, 0, 0, 0, 0, 0, 0, 0));
      cyc(1, 32'h44000000, 0, 0, 0, 0, 0, 0);
      chk("halt_set", 32'(pipe.halted), 32'd1);
      for (int i = 0; i < 2; i++) begin
         cyc(1, 32'h00411800, 0, 0, 0, 0, 0, 0);
         chk("halted_bubble", 32'(pipe.ex_valid), 32'd0);
         chk("halted_sticky", 32'(pipe.halted), 32'd1);
      end

      rst = 1'b1;
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      chk("rst2_halted", 32'(pipe.halted), 32'd0);
      chk("rst2_valid", 32'(pipe.ex_valid), 32'd0);
      expQ.push_back(mk(6'h00, 2, 1, 3, 0, 0, 32'h00001800, 0, 1));
      cyc(1, 32'h00411800, 0, 0, 0, 0, 0, 0);

      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      chk("queue_drained", 32'(expQ.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
